// File: rtl/alu_pkg.sv
// Shared definitions for the arbitrated ALU: opcodes, FSM states and index sizing.
package alu_pkg;

    localparam int DATA_W = 8;
    localparam int SEL_W  = 4;
    // Wide enough for the largest legal requester count (4).
    localparam int IDX_W  = 2;

    localparam logic [SEL_W-1:0] OP_ADD = 4'b1111;
    localparam logic [SEL_W-1:0] OP_SUB = 4'b1110;
    localparam logic [SEL_W-1:0] OP_INC = 4'b1101;
    localparam logic [SEL_W-1:0] OP_DEC = 4'b1100;
    localparam logic [SEL_W-1:0] OP_AND = 4'b0111;
    localparam logic [SEL_W-1:0] OP_OR  = 4'b0110;
    localparam logic [SEL_W-1:0] OP_XOR = 4'b0101;
    localparam logic [SEL_W-1:0] OP_NOT = 4'b0100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the requesters and the shared-ALU arbiter.
interface alu_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ*8-1:0] req_opa;
    logic [NUM_REQ*8-1:0] req_opb;
    logic [NUM_REQ*4-1:0] req_sel;
    logic [NUM_REQ-1:0]   rsp_valid;
    logic [NUM_REQ-1:0]   rsp_ready;
    logic [7:0]           rsp_result;
    logic                 rsp_carry;
    logic                 rsp_zero;
    logic                 rsp_err;

    modport master (
        output req_valid, req_opa, req_opb, req_sel, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_err
    );

    modport slave (
        input  req_valid, req_opa, req_opb, req_sel, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_err
    );
endinterface

// File: rtl/alu8_core.sv
// Combinational 8-bit ALU; arithmetic is done 9 bits wide so bit 8 is carry/borrow.
module alu8_core
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [SEL_W-1:0]  sel,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              err
);

    logic [DATA_W:0] sum9;

    always_comb begin
        sum9 = '0;
        err  = 1'b0;
        case (sel)
            OP_ADD:  sum9 = {1'b0, a} + {1'b0, b};
            OP_SUB:  sum9 = {1'b0, a} - {1'b0, b};
            OP_INC:  sum9 = {1'b0, a} + 9'd1;
            OP_DEC:  sum9 = {1'b0, a} - 9'd1;
            OP_AND:  sum9 = {1'b0, a & b};
            OP_OR:   sum9 = {1'b0, a | b};
            OP_XOR:  sum9 = {1'b0, a ^ b};
            OP_NOT:  sum9 = {1'b0, ~a};
            default: err  = 1'b1;
        endcase
    end

    assign result = sum9[DATA_W-1:0];
    assign carry  = sum9[DATA_W];

endmodule

// File: rtl/rr_pick.sv
// Round-robin picker: first asserted request at or after ptr, wrapping modulo NUM_REQ.
module rr_pick
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx
);

    logic found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!found && req[j] && (j == ((int'(ptr) + k) % NUM_REQ))) begin
                    found   = 1'b1;
                    gnt[j]  = 1'b1;
                    gnt_idx = IDX_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one alu8_core among NUM_REQ requesters: round-robin grant, registered
// operands (EXEC), registered result held until the owner accepts it (RESP).
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable,
    output logic         busy,
    alu_arbiter_if.slave bus
);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    rr_ptr_q;
    logic [IDX_W-1:0]    gnt_idx;
    logic [NUM_REQ-1:0]  gnt;
    logic [NUM_REQ-1:0]  owner_q;
    logic                accept;
    logic                rsp_done;

    logic [DATA_W-1:0]   opa_mux, opb_mux;
    logic [SEL_W-1:0]    sel_mux;
    logic [DATA_W-1:0]   opa_p0, opb_p0;
    logic [SEL_W-1:0]    sel_p0;

    logic [DATA_W-1:0]   alu_res;
    logic                alu_carry, alu_err;
    logic [DATA_W-1:0]   res_p1;
    logic                carry_p1, zero_p1, err_p1;

    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
    endfunction

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req     (bus.req_valid),
        .ptr     (rr_ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    alu8_core u_alu (
        .a      (opa_p0),
        .b      (opb_p0),
        .sel    (sel_p0),
        .result (alu_res),
        .carry  (alu_carry),
        .err    (alu_err)
    );

    // Grant is gated by rst_n so req_ready is low for the whole reset window.
    always_comb begin
        bus.req_ready = '0;
        if (rst_n && (state_q == IDLE) && enable) begin
            bus.req_ready = gnt;
        end
    end

    assign accept   = |bus.req_ready;
    assign rsp_done = (state_q == RESP) && |(bus.rsp_ready & owner_q);

    always_comb begin
        opa_mux = '0;
        opb_mux = '0;
        sel_mux = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (gnt[j]) begin
                opa_mux = bus.req_opa[8*j +: 8];
                opb_mux = bus.req_opb[8*j +: 8];
                sel_mux = bus.req_sel[4*j +: 4];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Stage p0: control state and grant bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                rr_ptr_q <= next_ptr(gnt_idx);
                owner_q  <= gnt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            opa_p0 <= opa_mux;
            opb_p0 <= opb_mux;
            sel_p0 <= sel_mux;
        end
    end

    // Stage p1: ALU outputs registered in EXEC, held through RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_p1   <= '0;
            carry_p1 <= 1'b0;
            zero_p1  <= 1'b0;
            err_p1   <= 1'b0;
        end else if (state_q == EXEC) begin
            res_p1   <= alu_res;
            carry_p1 <= alu_carry;
            zero_p1  <= (alu_res == '0);
            err_p1   <= alu_err;
        end
    end

    assign bus.rsp_valid  = (state_q == RESP) ? owner_q : '0;
    assign bus.rsp_result = res_p1;
    assign bus.rsp_carry  = carry_p1;
    assign bus.rsp_zero   = zero_p1;
    assign bus.rsp_err    = err_p1;
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: ops, round-robin, backpressure, enable, reset.
module tb_alu_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    logic enable;
    logic busy;
    int   n_vec = 0;
    int   n_err = 0;

    alu_arbiter_if #(.NUM_REQ(4)) bus ();

    alu_arbiter #(.NUM_REQ(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .busy   (busy),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int r, input logic [3:0] sel, input logic [7:0] a, input logic [7:0] b);
        bus.req_sel[4*r +: 4] = sel;
        bus.req_opa[8*r +: 8] = a;
        bus.req_opb[8*r +: 8] = b;
    endtask

    // Lone request from r starting in IDLE; response accepted on first RESP cycle.
    task automatic do_op(input string tag, input int r, input logic [3:0] sel,
                         input logic [7:0] a, input logic [7:0] b, input logic [7:0] er,
                         input logic ec, input logic ez, input logic ee);
        logic [3:0] oh;
        oh = 4'b0001 << r;
        set_req(r, sel, a, b);
        bus.req_valid = oh;
        bus.rsp_ready = oh;
        #1 chk({tag, "_ready"}, bus.req_ready, oh);
        @(negedge clk);
        bus.req_valid = '0;
        #1 chk({tag, "_exec_busy"}, busy, 1'b1);
        chk({tag, "_exec_noval"}, bus.rsp_valid, 4'b0);
        @(negedge clk);
        #1 chk({tag, "_valid"}, bus.rsp_valid, oh);
        chk({tag, "_result"}, bus.rsp_result, er);
        chk({tag, "_carry"}, bus.rsp_carry, ec);
        chk({tag, "_zero"}, bus.rsp_zero, ez);
        chk({tag, "_err"}, bus.rsp_err, ee);
        @(negedge clk);
        #1 chk({tag, "_idle"}, busy, 1'b0);
        chk({tag, "_done"}, bus.rsp_valid, 4'b0);
    endtask

    logic [3:0] rr_exp [5];
    logic [7:0] rr_res [4];

    initial begin
        rst_n = 1'b0;
        enable = 1'b1;
        bus.req_valid = 4'b1111;
        bus.rsp_ready = '0;
        bus.req_opa = '0;
        bus.req_opb = '0;
        bus.req_sel = '0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", bus.req_ready, 4'b0);
        chk("rst_rspv", bus.rsp_valid, 4'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_result", bus.rsp_result, 8'h00);
        chk("rst_flags", {bus.rsp_carry, bus.rsp_zero, bus.rsp_err}, 3'b000);
        bus.req_valid = '0;
        rst_n = 1'b1;
        @(negedge clk);

        // Single ops, one per requester so the pointer ends back at 0
        do_op("add", 0, 4'b1111, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0, 1'b0);
        do_op("sub", 1, 4'b1110, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0);
        do_op("and", 2, 4'b0111, 8'h0F, 8'hF0, 8'h00, 1'b0, 1'b1, 1'b0);
        do_op("bad", 3, 4'b0010, 8'h12, 8'h34, 8'h00, 1'b0, 1'b1, 1'b1);

        // Round-robin with all four valid
        set_req(0, 4'b1111, 8'h01, 8'h02); rr_res[0] = 8'h03;
        set_req(1, 4'b1110, 8'h05, 8'h03); rr_res[1] = 8'h02;
        set_req(2, 4'b0101, 8'hFF, 8'h0F); rr_res[2] = 8'hF0;
        set_req(3, 4'b1101, 8'h7F, 8'h00); rr_res[3] = 8'h80;
        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
        bus.req_valid = 4'b1111;
        bus.rsp_ready = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            #1 chk("rr_grant", bus.req_ready, rr_exp[g]);
            @(negedge clk);
            @(negedge clk);
            #1 chk("rr_rspv", bus.rsp_valid, rr_exp[g]);
            chk("rr_result", bus.rsp_result, rr_res[g % 4]);
            @(negedge clk);
        end
        // Pointer now at 1; only requester 2 valid
        bus.req_valid = 4'b0100;
        #1 chk("rr_only2", bus.req_ready, 4'b0100);
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        #1 chk("rr_only2_res", bus.rsp_result, 8'hF0);
        @(negedge clk);
        bus.rsp_ready = '0;

        // Backpressure: owner 1 stalls 5 cycles, requester 0 waiting
        set_req(1, 4'b0111, 8'h33, 8'h0F);
        set_req(0, 4'b1111, 8'h10, 8'h10);
        bus.req_valid = 4'b0010;
        #1 chk("bp_grant", bus.req_ready, 4'b0010);
        @(negedge clk);
        bus.req_valid = 4'b0001;
        #1 chk("bp_exec_noready", bus.req_ready, 4'b0);
        @(negedge clk);
        bus.rsp_ready = 4'b1101;
        for (int c = 0; c < 5; c++) begin
            #1 chk("bp_rspv", bus.rsp_valid, 4'b0010);
            chk("bp_result", bus.rsp_result, 8'h03);
            chk("bp_flags", {bus.rsp_carry, bus.rsp_zero, bus.rsp_err}, 3'b000);
            chk("bp_busy", busy, 1'b1);
            chk("bp_noready", bus.req_ready, 4'b0);
            @(negedge clk);
        end
        bus.rsp_ready = 4'b0010;
        #1 chk("bp_still", bus.rsp_valid, 4'b0010);
        @(negedge clk);
        bus.rsp_ready = 4'b0001;
        #1 chk("bp_next_grant", bus.req_ready, 4'b0001);
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        #1 chk("bp_next_rspv", bus.rsp_valid, 4'b0001);
        chk("bp_next_res", bus.rsp_result, 8'h20);
        @(negedge clk);

        // Enable low blocks grants; dropping it in EXEC does not stop the op
        enable = 1'b0;
        set_req(3, 4'b1100, 8'h00, 8'h00);
        bus.req_valid = 4'b1000;
        bus.rsp_ready = 4'b1000;
        for (int c = 0; c < 3; c++) begin
            #1 chk("en_nogrant", bus.req_ready, 4'b0);
            chk("en_idle", busy, 1'b0);
            @(negedge clk);
        end
        enable = 1'b1;
        #1 chk("en_grant", bus.req_ready, 4'b1000);
        @(negedge clk);
        enable = 1'b0;
        bus.req_valid = '0;
        #1 chk("en_exec_busy", busy, 1'b1);
        @(negedge clk);
        #1 chk("en_rspv", bus.rsp_valid, 4'b1000);
        chk("en_result", bus.rsp_result, 8'hFF);
        chk("en_carry", bus.rsp_carry, 1'b1);
        @(negedge clk);
        #1 chk("en_done", busy, 1'b0);
        enable = 1'b1;

        // Reset in RESP discards the op and resets the pointer
        set_req(2, 4'b0110, 8'h5A, 8'h00);
        bus.req_valid = 4'b0100;
        bus.rsp_ready = '0;
        #1 chk("mr_grant", bus.req_ready, 4'b0100);
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        #1 chk("mr_rspv", bus.rsp_valid, 4'b0100);
        chk("mr_result", bus.rsp_result, 8'h5A);
        rst_n = 1'b0;
        bus.req_valid = 4'b1111;
        #1 chk("mr_rst_rspv", bus.rsp_valid, 4'b0);
        chk("mr_rst_busy", busy, 1'b0);
        chk("mr_rst_result", bus.rsp_result, 8'h00);
        chk("mr_rst_ready", bus.req_ready, 4'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("mr_first_grant", bus.req_ready, 4'b0001);
        bus.rsp_ready = 4'b0001;
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk);
        #1 chk("mr_post_rspv", bus.rsp_valid, 4'b0001);
        chk("mr_post_res", bus.rsp_result, 8'h20);
        @(negedge clk);
        #1 chk("mr_post_idle", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
